// File: rtl/pt2272_decoder_param.sv
// pt2272_decoder_param: receives PT2262-format serial frames, checks the
// tri-state address against a_val/a_flt and presents confirmed data with a
// valid-transmission flag that times out when matching frames stop.
module pt2272_decoder_param #(
  parameter int N_ADDR      = 8,
  parameter int N_DATA      = 4,
  parameter int ALPHA_CLKS  = 100,
  parameter int CONFIRM     = 2,
  parameter int LATCH       = 1,
  parameter int HOLD_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cod_i,
  input  logic [N_ADDR-1:0] a_val,
  input  logic [N_ADDR-1:0] a_flt,
  output logic [N_DATA-1:0] d,
  output logic              vt,
  output logic              dv_pulse,
  output logic              err_pulse
);

  localparam int N_SYM  = N_ADDR + N_DATA;
  localparam int FW     = 2 * N_SYM;
  localparam int SAT_I  = 128 * ALPHA_CLKS;
  localparam int CW     = $clog2(SAT_I + 1);
  localparam int HOLD_I = HOLD_FRAMES * (N_SYM + 1) * 32 * ALPHA_CLKS;
  localparam int HW     = $clog2(HOLD_I + 1);
  localparam int SW     = $clog2(N_SYM + 1);
  localparam int CFW    = $clog2(CONFIRM + 1);

  localparam logic [CW-1:0]  W_SAT     = CW'(SAT_I);
  localparam logic [CW-1:0]  W_S_LO    = CW'(2 * ALPHA_CLKS);
  localparam logic [CW-1:0]  W_S_HI    = CW'(6 * ALPHA_CLKS);
  localparam logic [CW-1:0]  W_L_LO    = CW'(8 * ALPHA_CLKS);
  localparam logic [CW-1:0]  W_L_HI    = CW'(16 * ALPHA_CLKS);
  localparam logic [CW-1:0]  W_SYNC    = CW'(80 * ALPHA_CLKS);
  localparam logic [CW-1:0]  W_SYNC_M1 = CW'(80 * ALPHA_CLKS - 1);
  localparam logic [HW-1:0]  H_LOAD    = HW'(HOLD_I);
  localparam logic [SW-1:0]  SYM_LAST  = SW'(N_SYM - 1);
  localparam logic [CFW-1:0] CF_MAX    = CFW'(CONFIRM);

  typedef enum logic [1:0] {C_NONE = 2'd0, C_SHORT = 2'd1, C_LONG = 2'd2, C_ERR = 2'd3} cls_t;
  typedef enum logic [1:0] {HUNT = 2'd0, RECV = 2'd1, SYNC_WAIT = 2'd2, CHECK = 2'd3} state_t;

  // Width class of a finished high or low interval (sync-low handled separately).
  function automatic cls_t classify(input logic [CW-1:0] w);
    cls_t c;
    if (w >= W_S_LO && w < W_S_HI) begin
      c = C_SHORT;
    end else if (w >= W_L_LO && w < W_L_HI) begin
      c = C_LONG;
    end else begin
      c = C_ERR;
    end
    return c;
  endfunction

  logic            sync1_r, sync2_r, lvl_r;
  logic [CW-1:0]   cnt_r;
  cls_t            hi_cls_r, w_cls_s;
  state_t          state_r, state_n;
  logic [SW-1:0]   sym_cnt_r;
  logic            half_idx_r, half_r;
  logic [FW-1:0]   frame_r;
  logic [CFW-1:0]  conf_r, conf_n;
  logic [N_DATA-1:0] prev_r, data_s;
  logic [HW-1:0]   hold_r;
  logic            edge_s, fall_s, rise_s, sync_hit_s;
  logic            hi_bad_s, pair_bad_s, bit_ok_s, bit_val_s, sync_ok_s;
  logic            err_s, take_half_s, shift_s, clr_s, match_s, accept_s;
  logic [1:0]      sym_s;

  // A low longer than the sync threshold is reported once, when it crosses
  // the threshold, so an idle-low line still completes the trailing sync.
  assign edge_s     = (sync2_r != lvl_r);
  assign fall_s     = edge_s & lvl_r;
  assign rise_s     = edge_s & ~lvl_r & (cnt_r < W_SYNC);
  assign sync_hit_s = ~edge_s & ~lvl_r & (cnt_r == W_SYNC_M1);

  // Synchronize the input, measure each level length, remember the last high class.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      lvl_r    <= 1'b0;
      cnt_r    <= '0;
      hi_cls_r <= C_NONE;
    end else begin
      sync1_r <= cod_i;
      sync2_r <= sync1_r;
      if (edge_s) begin
        lvl_r <= sync2_r;
        cnt_r <= CW'(1);
      end else if (cnt_r != W_SAT) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (fall_s) begin
        hi_cls_r <= w_cls_s;
      end
    end
  end

  // Turn finished intervals into half-bit, sync and error events.
  always_comb begin
    w_cls_s    = classify(cnt_r);
    hi_bad_s   = fall_s && (w_cls_s == C_ERR);
    sync_ok_s  = sync_hit_s && (hi_cls_r == C_SHORT);
    bit_ok_s   = 1'b0;
    bit_val_s  = 1'b0;
    pair_bad_s = 1'b0;
    if (rise_s) begin
      if (hi_cls_r == C_SHORT && w_cls_s == C_LONG) begin
        bit_ok_s = 1'b1;
      end else if (hi_cls_r == C_LONG && w_cls_s == C_SHORT) begin
        bit_ok_s  = 1'b1;
        bit_val_s = 1'b1;
      end else begin
        pair_bad_s = 1'b1;
      end
    end else begin
      pair_bad_s = 1'b0;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_n;
    end
  end

  // Frame FSM next state and datapath controls.
  always_comb begin
    state_n     = state_r;
    err_s       = 1'b0;
    take_half_s = 1'b0;
    shift_s     = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      HUNT: begin
        if (sync_ok_s) begin
          state_n = RECV;
          clr_s   = 1'b1;
        end else begin
          state_n = HUNT;
        end
      end
      RECV: begin
        if (hi_bad_s || pair_bad_s || sync_hit_s) begin
          err_s   = 1'b1;
          state_n = HUNT;
        end else if (bit_ok_s) begin
          if (!half_idx_r) begin
            take_half_s = 1'b1;
          end else if ({half_r, bit_val_s} == 2'b10) begin
            err_s   = 1'b1;
            state_n = HUNT;
          end else begin
            shift_s = 1'b1;
            if (sym_cnt_r == SYM_LAST) begin
              state_n = SYNC_WAIT;
            end else begin
              state_n = RECV;
            end
          end
        end else begin
          state_n = RECV;
        end
      end
      SYNC_WAIT: begin
        if (sync_ok_s) begin
          state_n = CHECK;
        end else if (hi_bad_s || pair_bad_s || sync_hit_s || bit_ok_s) begin
          err_s   = 1'b1;
          state_n = HUNT;
        end else begin
          state_n = SYNC_WAIT;
        end
      end
      CHECK: begin
        state_n = RECV;
        clr_s   = 1'b1;
      end
      default: begin
        state_n = HUNT;
      end
    endcase
  end

  // Assemble half-bits into symbols and shift them into the frame register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt_r  <= '0;
      half_idx_r <= 1'b0;
      half_r     <= 1'b0;
      frame_r    <= '0;
    end else if (clr_s) begin
      sym_cnt_r  <= '0;
      half_idx_r <= 1'b0;
    end else if (take_half_s) begin
      half_r     <= bit_val_s;
      half_idx_r <= 1'b1;
    end else if (shift_s) begin
      frame_r    <= {frame_r[FW-3:0], half_r, bit_val_s};
      sym_cnt_r  <= sym_cnt_r + SW'(1);
      half_idx_r <= 1'b0;
    end
  end

  // Address/data compare and confirm-count update for the CHECK cycle.
  // Symbol codes in frame_r: 2'b00 = '0', 2'b11 = '1', 2'b01 = 'F'.
  always_comb begin
    match_s = 1'b1;
    data_s  = '0;
    sym_s   = 2'b00;
    for (int i = 0; i < N_ADDR; i++) begin
      sym_s   = frame_r[2*(N_DATA+i) +: 2];
      match_s = match_s & (a_flt[i] ? (sym_s == 2'b01) : (sym_s == {2{a_val[i]}}));
    end
    for (int j = 0; j < N_DATA; j++) begin
      sym_s     = frame_r[2*j +: 2];
      data_s[j] = sym_s[1];
      match_s   = match_s & (sym_s != 2'b01);
    end
    if (!match_s) begin
      conf_n = '0;
    end else if (conf_r != '0 && data_s == prev_r) begin
      conf_n = (conf_r == CF_MAX) ? CF_MAX : conf_r + CFW'(1);
    end else begin
      conf_n = CFW'(1);
    end
    accept_s = (state_r == CHECK) && match_s && (conf_n == CF_MAX);
  end

  // Confirm tracking, output registers and the valid-transmission hold timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d         <= '0;
      vt        <= 1'b0;
      dv_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      conf_r    <= '0;
      prev_r    <= '0;
      hold_r    <= '0;
    end else begin
      dv_pulse  <= accept_s;
      err_pulse <= err_s;
      if (err_s) begin
        conf_r <= '0;
      end else if (state_r == CHECK) begin
        conf_r <= conf_n;
      end
      if (state_r == CHECK && match_s) begin
        prev_r <= data_s;
      end
      if (accept_s) begin
        d      <= data_s;
        vt     <= 1'b1;
        hold_r <= H_LOAD;
      end else if (vt && hold_r == HW'(1)) begin
        vt     <= 1'b0;
        hold_r <= '0;
        if (LATCH == 0) begin
          d <= '0;
        end
      end else if (vt) begin
        hold_r <= hold_r - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pt2272_decoder_param.sv
// tb_pt2272_decoder_param: directed frame vectors plus corner sequences for
// glitches, reset mid-frame and the vt hold timeout (alpha = 4 clk).
module tb_pt2272_decoder_param;

  localparam int A = 4;
  localparam int HOLD = 4 * 13 * 32 * A;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cod = 1'b0;
  logic [7:0] a_val = 8'h00;
  logic [7:0] a_flt = 8'h00;
  logic [3:0] d, d0;
  logic       vt, dv_pulse, err_pulse, vt0, dv0_pulse, err0_pulse;

  int total = 0;
  int bad = 0;
  int cyc = 0, dv_cyc = 0, fall_cyc = 0;
  int dv_cnt = 0, err_cnt = 0, dv0_cnt = 0, err0_cnt = 0;
  logic vt_prev = 1'b0;
  logic [3:0] d0_at_dv = 4'h0;

  pt2272_decoder_param #(.N_ADDR(8), .N_DATA(4), .ALPHA_CLKS(A), .CONFIRM(2),
                         .LATCH(1), .HOLD_FRAMES(4)) u_dut (
    .clk(clk), .reset(reset), .cod_i(cod), .a_val(a_val), .a_flt(a_flt),
    .d(d), .vt(vt), .dv_pulse(dv_pulse), .err_pulse(err_pulse));

  pt2272_decoder_param #(.N_ADDR(8), .N_DATA(4), .ALPHA_CLKS(A), .CONFIRM(2),
                         .LATCH(0), .HOLD_FRAMES(4)) u_dut0 (
    .clk(clk), .reset(reset), .cod_i(cod), .a_val(a_val), .a_flt(a_flt),
    .d(d0), .vt(vt0), .dv_pulse(dv0_pulse), .err_pulse(err0_pulse));

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    vt_prev <= vt;
    if (vt_prev && !vt) fall_cyc <= cyc;
    if (dv_pulse) begin
      dv_cnt   <= dv_cnt + 1;
      dv_cyc   <= cyc;
      d0_at_dv <= d0;
    end
    if (err_pulse) err_cnt <= err_cnt + 1;
    if (dv0_pulse) dv0_cnt <= dv0_cnt + 1;
    if (err0_pulse) err0_cnt <= err0_cnt + 1;
  end

  typedef struct {
    string      nm;
    logic [7:0] a_val, a_flt, tx_av, tx_af;
    logic [3:0] tx_df;
    logic [11:0] tx_d;   // data of frame f in bits [4f+3:4f]
    int         nfr;
    int         exp_dv;
    logic [3:0] exp_d;
    logic       exp_vt;
  } vec_t;

  vec_t vec [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic lvl(input logic v, input int n);
    cod = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic half(input logic b);
    if (b) begin lvl(1'b1, 12*A); lvl(1'b0, 4*A); end
    else   begin lvl(1'b1, 4*A);  lvl(1'b0, 12*A); end
  endtask

  task automatic send_sync();
    lvl(1'b1, 4*A);
    lvl(1'b0, 124*A);
  endtask

  task automatic send_syms(input logic [7:0] av, input logic [7:0] af,
                           input logic [3:0] dd, input logic [3:0] df, input int nsym);
    logic b, f;
    for (int k = 0; k < nsym; k++) begin
      if (k < 8) begin b = av[7-k]; f = af[7-k]; end
      else       begin b = dd[11-k]; f = df[11-k]; end
      if (f) begin half(1'b0); half(1'b1); end
      else   begin half(b); half(b); end
    end
  endtask

  task automatic send_frame(input logic [7:0] av, input logic [7:0] af,
                            input logic [3:0] dd, input logic [3:0] df);
    send_syms(av, af, dd, df, 12);
    send_sync();
  endtask

  task automatic do_reset();
    cod = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int dv_b, err_b, n;
    vec[0] = '{"basic",     8'hA5, 8'h00, 8'hA5, 8'h00, 4'h0, 12'hAAA, 2, 1, 4'hA, 1'b1};
    vec[1] = '{"chg_data",  8'hA5, 8'h00, 8'hA5, 8'h00, 4'h0, 12'h053, 2, 0, 4'h0, 1'b0};
    vec[2] = '{"confirm3",  8'hA5, 8'h00, 8'hA5, 8'h00, 4'h0, 12'h553, 3, 1, 4'h5, 1'b1};
    vec[3] = '{"float_ok",  8'hA5, 8'h81, 8'hA5, 8'h81, 4'h0, 12'hCCC, 2, 1, 4'hC, 1'b1};
    vec[4] = '{"float_bad", 8'hA5, 8'h81, 8'h25, 8'h01, 4'h0, 12'hCCC, 2, 0, 4'h0, 1'b0};
    vec[5] = '{"addr_bad",  8'h3C, 8'h00, 8'h3D, 8'h00, 4'h0, 12'h111, 2, 0, 4'h0, 1'b0};
    vec[6] = '{"data_f",    8'h3C, 8'h00, 8'h3C, 8'h00, 4'h4, 12'h111, 2, 0, 4'h0, 1'b0};
    vec[7] = '{"repeat",    8'h3C, 8'h00, 8'h3C, 8'h00, 4'h0, 12'h666, 3, 2, 4'h6, 1'b1};
    vec[8] = '{"all_f",     8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0, 12'hFFF, 2, 1, 4'hF, 1'b1};

    // Reset state while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_vt", 32'(vt), 32'h0);
    chk("rst_dv", 32'(dv_pulse), 32'h0);
    chk("rst_err", 32'(err_pulse), 32'h0);

    // Table-driven frames.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      a_val = vec[v].a_val;
      a_flt = vec[v].a_flt;
      dv_b = dv_cnt;
      err_b = err_cnt;
      send_sync();
      for (int f = 0; f < vec[v].nfr; f++)
        send_frame(vec[v].tx_av, vec[v].tx_af, vec[v].tx_d[4*f +: 4], vec[v].tx_df);
      chk({vec[v].nm, "_dv"}, 32'(dv_cnt - dv_b), 32'(vec[v].exp_dv));
      chk({vec[v].nm, "_err"}, 32'(err_cnt - err_b), 32'h0);
      chk({vec[v].nm, "_d"}, 32'(d), 32'(vec[v].exp_d));
      chk({vec[v].nm, "_vt"}, 32'(vt), 32'(vec[v].exp_vt));
    end

    // Short glitch mid-frame: error, confirm restarts.
    do_reset();
    a_val = 8'hA5;
    a_flt = 8'h00;
    dv_b = dv_cnt;
    err_b = err_cnt;
    send_sync();
    send_frame(8'hA5, 8'h00, 4'h9, 4'h0);
    send_syms(8'hA5, 8'h00, 4'h9, 4'h0, 3);
    lvl(1'b1, 7);
    lvl(1'b0, 12*A);
    chk("glitch_err", 32'(err_cnt - err_b), 32'h1);
    send_sync();
    send_frame(8'hA5, 8'h00, 4'h9, 4'h0);
    chk("glitch_no_early_dv", 32'(dv_cnt - dv_b), 32'h0);
    send_frame(8'hA5, 8'h00, 4'h9, 4'h0);
    chk("glitch_dv", 32'(dv_cnt - dv_b), 32'h1);
    chk("glitch_d", 32'(d), 32'h9);
    chk("glitch_vt", 32'(vt), 32'h1);

    // Reset in the 6th symbol of a frame while vt is high.
    send_syms(8'hA5, 8'h00, 4'h6, 4'h0, 5);
    half(1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_d", 32'(d), 32'h0);
    chk("midrst_vt", 32'(vt), 32'h0);
    chk("midrst_dv", 32'(dv_pulse), 32'h0);
    chk("midrst_err", 32'(err_pulse), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dv_b = dv_cnt;
    send_sync();
    send_frame(8'hA5, 8'h00, 4'h6, 4'h0);
    chk("midrst_no_early_dv", 32'(dv_cnt - dv_b), 32'h0);
    send_frame(8'hA5, 8'h00, 4'h6, 4'h0);
    chk("midrst_dv", 32'(dv_cnt - dv_b), 32'h1);
    chk("midrst_d_after", 32'(d), 32'h6);

    // Idle low line: vt times out; latched vs momentary data.
    n = 0;
    while (vt && n < 8000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    chk("hold_vt_fell", 32'(vt), 32'h0);
    chk("hold_len", 32'(fall_cyc - dv_cyc), 32'(HOLD));
    chk("hold_latch_d", 32'(d), 32'h6);
    chk("hold_mom_d_at_dv", 32'(d0_at_dv), 32'h6);
    chk("hold_mom_d", 32'(d0), 32'h0);
    chk("hold_mom_vt", 32'(vt0), 32'h0);
    chk("inst_dv_cnt", 32'(dv0_cnt), 32'(dv_cnt));
    chk("inst_err_cnt", 32'(err0_cnt), 32'(err_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
